lt_pytxbufctrl: RTL and testbench

Parametrised per-LT_ADDR transmit payload buffer controller with hardware ARQ retransmission. Each logical transport owns a ping-pong bank pair: the MCU fills one bank while link control transmits the other. Banks swap automatically on a positive acknowledgement, and SEQN and FLOW are tracked per LT. The block sits between the MCU bus (bsm side) and the link-control bit serialiser, and replaces the single-channel s1a-toggle scheme for ACL traffic.

---
 rtl/bt_bufpkg.sv | 27 ++
 rtl/pybuf_dpram.sv | 39 +++
 rtl/lt_pytxbufctrl.sv | 178 +++++++++++++++++
 tb/tb_lt_pytxbufctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bt_bufpkg.sv
// Shared sizing and per-LT state decode for the ACL transmit payload buffers.
package bt_bufpkg;

  localparam int unsigned NUM_LT_DEF = 8;
  localparam int unsigned DW_DEF     = 32;
  localparam int unsigned AW_DEF     = 7;
  localparam int unsigned BANK_W     = 1;
  localparam int unsigned NUM_BANK   = 2;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    LT_IDLE     = 2'd0,
    LT_LOADED   = 2'd1,
    LT_WAIT_ACK = 2'd2
  } lt_state_e;

  function automatic lt_state_e lt_state(input logic full_act, input logic inflight);
    if (inflight) return LT_WAIT_ACK;
    if (full_act) return LT_LOADED;
    return LT_IDLE;
  endfunction

endpackage

// File: rtl/pybuf_dpram.sv
// Payload RAM: host write port, link-control read port with a registered output word.
module pybuf_dpram
  import bt_bufpkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DEPTH  = 2048
) (
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk_6M) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // Only the output word is reset so the serialiser bit starts at 0; the array is left as-is.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lt_pytxbufctrl.sv
// Per-LT ping-pong transmit payload buffers with hardware ARQ: the host fills one bank
// while link control sends the other; a positive ACK releases the sent bank and swaps.
module lt_pytxbufctrl
  import bt_bufpkg::*;
#(
  parameter  int unsigned NUM_LT = NUM_LT_DEF,
  parameter  int unsigned DW     = DW_DEF,
  parameter  int unsigned AW     = AW_DEF,
  localparam int unsigned LTW    = idx_w(NUM_LT),
  localparam int unsigned BW     = idx_w(DW)
) (
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic              host_we,
  input  logic [LTW-1:0]    host_lt,
  input  logic [AW-1:0]     host_addr,
  input  logic [DW-1:0]     host_din,
  input  logic              host_commit_p,
  input  logic              host_flush_p,
  input  logic [LTW-1:0]    tx_lt,
  input  logic              tx_packet_st_p,
  input  logic              lnc_rd,
  input  logic [AW-1:0]     lnc_addr,
  input  logic [BW-1:0]     lnc_bitsel,
  input  logic              rx_ack_p,
  input  logic [LTW-1:0]    rx_lt,
  input  logic              rx_arqn,
  input  logic              rx_flow,
  output logic              tx_havepy,
  output logic              tx_seqn,
  output logic              lnc_bit,
  output logic [NUM_LT-1:0] txbuf_full,
  output logic              tx_done_p,
  output logic [LTW-1:0]    tx_done_lt,
  output logic              commit_err_p
);

  localparam int unsigned ADDR_W = LTW + BANK_W + AW;
  localparam int unsigned DEPTH  = NUM_LT * NUM_BANK * (2 ** AW);

  logic [NUM_LT-1:0]      active_q, active_d;
  logic [NUM_LT-1:0][1:0] full_q, full_d;
  logic [NUM_LT-1:0]      inflight_q, inflight_d;
  logic [NUM_LT-1:0]      seqn_q, seqn_d;
  logic [NUM_LT-1:0]      flow_go_q, flow_go_d;
  logic                   tx_done_q, tx_done_d;
  logic [LTW-1:0]         tx_done_lt_q, tx_done_lt_d;
  logic                   commit_err_q, commit_err_d;
  logic [BW-1:0]          bitsel_q, bitsel_d;

  logic [NUM_LT-1:0] flush_v, commit_v, ack_v, txst_v;
  lt_state_e         st_v [NUM_LT];

  logic              wr_en;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [DW-1:0]     rd_word;

  assign tx_havepy = full_q[tx_lt][active_q[tx_lt]] & flow_go_q[tx_lt];
  assign tx_seqn   = seqn_q[tx_lt];

  always_comb begin
    for (int i = 0; i < NUM_LT; i++) begin
      txbuf_full[i] = full_q[i][~active_q[i]];
    end
  end

  // Decode the per-LT event strobes and the derived state once, ahead of the update logic.
  always_comb begin
    flush_v  = '0;
    commit_v = '0;
    ack_v    = '0;
    txst_v   = '0;
    for (int i = 0; i < NUM_LT; i++) begin
      st_v[i]     = lt_state(full_q[i][active_q[i]], inflight_q[i]);
      flush_v[i]  = host_flush_p   && (host_lt == LTW'(i));
      commit_v[i] = host_commit_p  && (host_lt == LTW'(i));
      ack_v[i]    = rx_ack_p       && (rx_lt   == LTW'(i));
      txst_v[i]   = tx_packet_st_p && tx_havepy && (tx_lt == LTW'(i));
    end
  end

  always_comb begin
    active_d     = active_q;
    full_d       = full_q;
    inflight_d   = inflight_q;
    seqn_d       = seqn_q;
    flow_go_d    = flow_go_q;
    tx_done_d    = 1'b0;
    tx_done_lt_d = tx_done_lt_q;
    commit_err_d = 1'b0;
    for (int i = 0; i < NUM_LT; i++) begin
      if (flush_v[i]) begin
        full_d[i]     = 2'b00;
        inflight_d[i] = 1'b0;
        flow_go_d[i]  = 1'b1;
      end else begin
        // An empty active bank is refilled by promoting the bank just committed.
        if (commit_v[i]) begin
          if (full_q[i][~active_q[i]]) begin
            commit_err_d = 1'b1;
          end else begin
            full_d[i][~active_q[i]] = 1'b1;
            if (st_v[i] == LT_IDLE) active_d[i] = ~active_q[i];
          end
        end
        if (ack_v[i]) begin
          flow_go_d[i] = rx_flow;
          if ((st_v[i] == LT_WAIT_ACK) && rx_arqn) begin
            full_d[i][active_q[i]] = 1'b0;
            inflight_d[i]          = 1'b0;
            active_d[i]            = ~active_q[i];
            tx_done_d              = 1'b1;
            tx_done_lt_d           = LTW'(i);
          end
        end else if (txst_v[i] && (st_v[i] == LT_LOADED)) begin
          inflight_d[i] = 1'b1;
          seqn_d[i]     = ~seqn_q[i];
        end
      end
    end
  end

  always_comb begin
    bitsel_d = bitsel_q;
    if (lnc_rd) bitsel_d = lnc_bitsel;
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      active_q     <= '0;
      full_q       <= '0;
      inflight_q   <= '0;
      seqn_q       <= '0;
      flow_go_q    <= '1;
      tx_done_q    <= 1'b0;
      tx_done_lt_q <= '0;
      commit_err_q <= 1'b0;
      bitsel_q     <= '0;
    end else begin
      active_q     <= active_d;
      full_q       <= full_d;
      inflight_q   <= inflight_d;
      seqn_q       <= seqn_d;
      flow_go_q    <= flow_go_d;
      tx_done_q    <= tx_done_d;
      tx_done_lt_q <= tx_done_lt_d;
      commit_err_q <= commit_err_d;
      bitsel_q     <= bitsel_d;
    end
  end

  assign tx_done_p    = tx_done_q;
  assign tx_done_lt   = tx_done_lt_q;
  assign commit_err_p = commit_err_q;

  // Host always targets the fill bank, link control the active bank, so they never collide.
  assign wr_en = host_we & ~full_q[host_lt][~active_q[host_lt]];
  assign waddr = {host_lt, ~active_q[host_lt], host_addr};
  assign raddr = {tx_lt, active_q[tx_lt], lnc_addr};

  pybuf_dpram #(
    .DW     (DW),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_6M (clk_6M),
    .rstz   (rstz),
    .we     (wr_en),
    .waddr  (waddr),
    .wdata  (host_din),
    .re     (lnc_rd),
    .raddr  (raddr),
    .rdata  (rd_word)
  );

  assign lnc_bit = rd_word[bitsel_q];

endmodule

// File: tb/tb_lt_pytxbufctrl.sv
// Directed bench for lt_pytxbufctrl: a vector table for the basic TX/ARQ flow, then hand-written corner sequences.
module tb_lt_pytxbufctrl;
  import bt_bufpkg::*;

  localparam int unsigned NUM_LT = 8;
  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 7;
  localparam int unsigned LTW    = 3;
  localparam int unsigned BW     = 5;

  logic              clk_6M = 1'b0;
  logic              rstz = 1'b0;
  logic              host_we = 1'b0;
  logic [LTW-1:0]    host_lt = '0;
  logic [AW-1:0]     host_addr = '0;
  logic [DW-1:0]     host_din = '0;
  logic              host_commit_p = 1'b0;
  logic              host_flush_p = 1'b0;
  logic [LTW-1:0]    tx_lt = '0;
  logic              tx_packet_st_p = 1'b0;
  logic              lnc_rd = 1'b0;
  logic [AW-1:0]     lnc_addr = '0;
  logic [BW-1:0]     lnc_bitsel = '0;
  logic              rx_ack_p = 1'b0;
  logic [LTW-1:0]    rx_lt = '0;
  logic              rx_arqn = 1'b0;
  logic              rx_flow = 1'b0;
  logic              tx_havepy, tx_seqn, lnc_bit, tx_done_p, commit_err_p;
  logic [NUM_LT-1:0] txbuf_full;
  logic [LTW-1:0]    tx_done_lt;

  always #10 clk_6M = ~clk_6M;

  lt_pytxbufctrl #(.NUM_LT(NUM_LT), .DW(DW), .AW(AW)) dut (
    .clk_6M(clk_6M), .rstz(rstz),
    .host_we(host_we), .host_lt(host_lt), .host_addr(host_addr), .host_din(host_din),
    .host_commit_p(host_commit_p), .host_flush_p(host_flush_p),
    .tx_lt(tx_lt), .tx_packet_st_p(tx_packet_st_p),
    .lnc_rd(lnc_rd), .lnc_addr(lnc_addr), .lnc_bitsel(lnc_bitsel),
    .rx_ack_p(rx_ack_p), .rx_lt(rx_lt), .rx_arqn(rx_arqn), .rx_flow(rx_flow),
    .tx_havepy(tx_havepy), .tx_seqn(tx_seqn), .lnc_bit(lnc_bit),
    .txbuf_full(txbuf_full), .tx_done_p(tx_done_p), .tx_done_lt(tx_done_lt),
    .commit_err_p(commit_err_p)
  );

  typedef enum logic [2:0] {OP_NOP, OP_WR, OP_COMMIT, OP_TXST, OP_ACK, OP_RD} op_e;

  typedef struct {
    op_e               op;
    logic [LTW-1:0]    lt;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     din;
    logic [BW-1:0]     bsel;
    logic              arqn;
    logic              flow;
    logic              chk_bit;
    logic              exp_bit;
    logic              exp_havepy;
    logic              exp_seqn;
    logic              exp_done;
    logic [NUM_LT-1:0] exp_full;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input op_e op, input int lt, input int addr, input logic [31:0] din,
                              input int bsel, input int arqn, input int flow, input int cb,
                              input int eb, input int h, input int s, input int d, input int f);
    vec_t v;
    v.op = op; v.lt = lt[LTW-1:0]; v.addr = addr[AW-1:0]; v.din = din;
    v.bsel = bsel[BW-1:0]; v.arqn = arqn[0]; v.flow = flow[0];
    v.chk_bit = cb[0]; v.exp_bit = eb[0]; v.exp_havepy = h[0]; v.exp_seqn = s[0];
    v.exp_done = d[0]; v.exp_full = f[NUM_LT-1:0];
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk_6M);
    #1;
    host_we = 1'b0; host_commit_p = 1'b0; host_flush_p = 1'b0;
    tx_packet_st_p = 1'b0; lnc_rd = 1'b0; rx_ack_p = 1'b0;
  endtask

  task automatic wr(input int lt, input int addr, input logic [31:0] din);
    host_we = 1'b1; host_lt = lt[LTW-1:0]; host_addr = addr[AW-1:0]; host_din = din;
    cyc();
  endtask

  task automatic commit(input int lt);
    host_commit_p = 1'b1; host_lt = lt[LTW-1:0];
    cyc();
  endtask

  task automatic txst(input int lt);
    tx_lt = lt[LTW-1:0]; tx_packet_st_p = 1'b1;
    cyc();
  endtask

  task automatic ack(input int lt, input int arqn, input int flow);
    rx_ack_p = 1'b1; rx_lt = lt[LTW-1:0]; rx_arqn = arqn[0]; rx_flow = flow[0];
    cyc();
  endtask

  task automatic rd(input int lt, input int addr, input int bsel);
    tx_lt = lt[LTW-1:0]; lnc_rd = 1'b1; lnc_addr = addr[AW-1:0]; lnc_bitsel = bsel[BW-1:0];
    cyc();
  endtask

  task automatic apply(input vec_t v);
    tx_lt = v.lt;
    case (v.op)
      OP_WR:     begin host_we = 1'b1; host_lt = v.lt; host_addr = v.addr; host_din = v.din; end
      OP_COMMIT: begin host_commit_p = 1'b1; host_lt = v.lt; end
      OP_TXST:   tx_packet_st_p = 1'b1;
      OP_ACK:    begin rx_ack_p = 1'b1; rx_lt = v.lt; rx_arqn = v.arqn; rx_flow = v.flow; end
      OP_RD:     begin lnc_rd = 1'b1; lnc_addr = v.addr; lnc_bitsel = v.bsel; end
      default:   ;
    endcase
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    // LT3: load four words, send, read back, then two NAKs with retransmits and a final ACK.
    vt.push_back(mk(OP_WR,     3, 0, 32'hA5A5_0001, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    vt.push_back(mk(OP_WR,     3, 1, 32'h0000_8000, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    vt.push_back(mk(OP_WR,     3, 2, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    vt.push_back(mk(OP_WR,     3, 3, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    vt.push_back(mk(OP_COMMIT, 3, 0, 32'h0,         0, 0, 0, 0, 0, 1, 0, 0, 8'h00));
    vt.push_back(mk(OP_TXST,   3, 0, 32'h0,         0, 0, 0, 0, 0, 1, 1, 0, 8'h00));
    vt.push_back(mk(OP_RD,     3, 0, 32'h0,         0, 0, 0, 1, 1, 1, 1, 0, 8'h00));
    vt.push_back(mk(OP_RD,     3, 1, 32'h0,        15, 0, 0, 1, 1, 1, 1, 0, 8'h00));
    vt.push_back(mk(OP_RD,     3, 1, 32'h0,        14, 0, 0, 1, 0, 1, 1, 0, 8'h00));
    vt.push_back(mk(OP_RD,     3, 2, 32'h0,         0, 0, 0, 1, 0, 1, 1, 0, 8'h00));
    vt.push_back(mk(OP_RD,     3, 2, 32'h0,        31, 0, 0, 1, 1, 1, 1, 0, 8'h00));
    vt.push_back(mk(OP_RD,     3, 3, 32'h0,         3, 0, 0, 1, 1, 1, 1, 0, 8'h00));
    vt.push_back(mk(OP_NOP,    3, 0, 32'h0,         0, 0, 0, 1, 1, 1, 1, 0, 8'h00));
    vt.push_back(mk(OP_ACK,    3, 0, 32'h0,         0, 0, 1, 0, 0, 1, 1, 0, 8'h00));
    vt.push_back(mk(OP_TXST,   3, 0, 32'h0,         0, 0, 0, 0, 0, 1, 1, 0, 8'h00));
    vt.push_back(mk(OP_ACK,    3, 0, 32'h0,         0, 0, 1, 0, 0, 1, 1, 0, 8'h00));
    vt.push_back(mk(OP_TXST,   3, 0, 32'h0,         0, 0, 0, 0, 0, 1, 1, 0, 8'h00));
    vt.push_back(mk(OP_ACK,    3, 0, 32'h0,         0, 1, 1, 0, 0, 0, 1, 1, 8'h00));
    vt.push_back(mk(OP_NOP,    3, 0, 32'h0,         0, 0, 0, 0, 0, 0, 1, 0, 8'h00));

    // Reset state
    repeat (2) @(posedge clk_6M);
    #1;
    chk("rst_full",    32'(txbuf_full),   32'h0);
    chk("rst_havepy",  32'(tx_havepy),    32'h0);
    chk("rst_seqn",    32'(tx_seqn),      32'h0);
    chk("rst_done",    32'(tx_done_p),    32'h0);
    chk("rst_done_lt", 32'(tx_done_lt),   32'h0);
    chk("rst_err",     32'(commit_err_p), 32'h0);
    chk("rst_bit",     32'(lnc_bit),      32'h0);
    rstz = 1'b1;
    cyc();

    for (int k = 0; k < vt.size(); k++) begin
      apply(vt[k]);
      chk($sformatf("v%0d_havepy", k), 32'(tx_havepy),    32'(vt[k].exp_havepy));
      chk($sformatf("v%0d_seqn", k),   32'(tx_seqn),      32'(vt[k].exp_seqn));
      chk($sformatf("v%0d_done", k),   32'(tx_done_p),    32'(vt[k].exp_done));
      chk($sformatf("v%0d_full", k),   32'(txbuf_full),   32'(vt[k].exp_full));
      chk($sformatf("v%0d_err", k),    32'(commit_err_p), 32'h0);
      if (vt[k].exp_done) chk($sformatf("v%0d_done_lt", k), 32'(tx_done_lt), 32'(vt[k].lt));
      if (vt[k].chk_bit)  chk($sformatf("v%0d_bit", k),     32'(lnc_bit),    32'(vt[k].exp_bit));
    end

    // LT4: second bank pre-committed during WAIT_ACK, then flow-off / flow-on.
    tx_lt = 3'd4;
    wr(4, 0, 32'h0000_0002);
    commit(4);
    chk("lt4_loaded", 32'(tx_havepy), 32'h1);
    txst(4);
    chk("lt4_seqn1", 32'(tx_seqn), 32'h1);
    wr(4, 0, 32'h8000_0000);
    commit(4);
    chk("lt4_prefull", 32'(txbuf_full[4]), 32'h1);
    ack(4, 1, 1);
    chk("lt4_done",      32'(tx_done_p),     32'h1);
    chk("lt4_done_lt",   32'(tx_done_lt),    32'h4);
    chk("lt4_swap_load", 32'(tx_havepy),     32'h1);
    chk("lt4_fill_free", 32'(txbuf_full[4]), 32'h0);
    ack(4, 0, 0);
    chk("lt4_flow_off", 32'(tx_havepy), 32'h0);
    chk("lt4_no_done",  32'(tx_done_p), 32'h0);
    txst(4);
    chk("lt4_txst_ign", 32'(tx_seqn), 32'h1);
    ack(4, 0, 1);
    chk("lt4_flow_on", 32'(tx_havepy), 32'h1);
    txst(4);
    chk("lt4_seqn0", 32'(tx_seqn), 32'h0);
    rd(4, 0, 31);
    chk("lt4_bank2_b31", 32'(lnc_bit), 32'h1);
    rd(4, 0, 1);
    chk("lt4_bank2_b1", 32'(lnc_bit), 32'h0);

    // LT5: commit in the same cycle as the ACK that releases the active bank.
    tx_lt = 3'd5;
    wr(5, 0, 32'h0000_0001);
    commit(5);
    txst(5);
    wr(5, 0, 32'h0000_0002);
    host_commit_p = 1'b1; host_lt = 3'd5;
    rx_ack_p = 1'b1; rx_lt = 3'd5; rx_arqn = 1'b1; rx_flow = 1'b1;
    cyc();
    chk("lt5_done",   32'(tx_done_p),     32'h1);
    chk("lt5_err",    32'(commit_err_p),  32'h0);
    chk("lt5_loaded", 32'(tx_havepy),     32'h1);
    chk("lt5_full",   32'(txbuf_full[5]), 32'h0);
    txst(5);
    chk("lt5_seqn0", 32'(tx_seqn), 32'h0);
    rd(5, 0, 1);
    chk("lt5_bit", 32'(lnc_bit), 32'h1);

    // LT6: commit to an already-full fill bank; the blocked write must not land.
    tx_lt = 3'd6;
    wr(6, 0, 32'h0000_00F0);
    commit(6);
    wr(6, 0, 32'h0000_000F);
    commit(6);
    chk("lt6_full",   32'(txbuf_full[6]), 32'h1);
    chk("lt6_no_err", 32'(commit_err_p),  32'h0);
    wr(6, 0, 32'hFFFF_FFFF);
    commit(6);
    chk("lt6_err", 32'(commit_err_p), 32'h1);
    cyc();
    chk("lt6_err_clr", 32'(commit_err_p), 32'h0);
    txst(6);
    ack(6, 1, 1);
    chk("lt6_loaded", 32'(tx_havepy), 32'h1);
    rd(6, 0, 4);
    chk("lt6_b4", 32'(lnc_bit), 32'h0);
    rd(6, 0, 0);
    chk("lt6_b0", 32'(lnc_bit), 32'h1);

    // LT1 flush wins over its ACK while LT2 starts a packet in the same cycle.
    wr(1, 0, 32'h0000_0001);
    commit(1);
    txst(1);
    wr(2, 0, 32'h0000_0001);
    commit(2);
    tx_lt = 3'd2;
    #1;
    chk("lt2_loaded", 32'(tx_havepy), 32'h1);
    host_flush_p = 1'b1; host_lt = 3'd1;
    rx_ack_p = 1'b1; rx_lt = 3'd1; rx_arqn = 1'b1; rx_flow = 1'b1;
    tx_packet_st_p = 1'b1;
    cyc();
    chk("flush_no_done", 32'(tx_done_p),  32'h0);
    chk("flush_full",    32'(txbuf_full), 32'h0);
    chk("lt2_seqn",      32'(tx_seqn),    32'h1);
    chk("lt2_havepy",    32'(tx_havepy),  32'h1);
    tx_lt = 3'd1;
    #1;
    chk("lt1_idle",      32'(tx_havepy), 32'h0);
    chk("lt1_seqn_kept", 32'(tx_seqn),   32'h1);
    ack(1, 1, 1);
    chk("lt1_ack_idle", 32'(tx_done_p), 32'h0);

    // Reset mid-operation
    tx_lt = 3'd4;
    rstz = 1'b0;
    #1;
    chk("mid_rst_full",   32'(txbuf_full), 32'h0);
    chk("mid_rst_havepy", 32'(tx_havepy),  32'h0);
    chk("mid_rst_seqn",   32'(tx_seqn),    32'h0);
    @(negedge clk_6M);
    rstz = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
